// File: rtl/ysyx_23060251_lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_23060251_lsu_pkg : shared encodings and op bundle for the LSU   rev 1.0
// ----------------------------------------------------------------------------
package ysyx_23060251_lsu_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_FAULT    = 2'd2;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic                wen;
    logic                ren;
    logic                sgn;
    logic [1:0]          size;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
    logic [4:0]          rd;
  } lsu_op_t;

  // Byte-lane strobes of an access starting at lane 0.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001;
      SIZE_HALF: m = 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_align : lane alignment, load extension and op legality checks   rev 1.0
// ----------------------------------------------------------------------------
module lsu_align
  import ysyx_23060251_lsu_pkg::*;
(
  input  logic                st_wen,
  input  logic                st_ren,
  input  logic [1:0]          st_size,
  input  logic [1:0]          st_offset,
  input  logic [LSU_XLEN-1:0] st_wdata,
  output logic [7:0]          st_mask,
  output logic [LSU_XLEN-1:0] st_wdata_sh,
  output logic                misaligned,
  output logic                illegal,
  input  logic                ld_sgn,
  input  logic [1:0]          ld_size,
  input  logic [1:0]          ld_offset,
  input  logic [LSU_XLEN-1:0] ld_rdata,
  output logic [LSU_XLEN-1:0] ld_data
);

  logic [3:0]          lane_mask;
  logic [LSU_XLEN-1:0] ld_shifted;

  always_comb begin
    lane_mask   = size_mask(st_size) << st_offset;
    st_mask     = {4'b0000, lane_mask};
    st_wdata_sh = st_wdata << {st_offset, 3'b000};
    illegal     = (st_wen && st_ren) || (st_size == SIZE_ILL);
    misaligned  = ((st_size == SIZE_HALF) && st_offset[0]) ||
                  ((st_size == SIZE_WORD) && (st_offset != 2'b00));
  end

  always_comb begin
    ld_shifted = ld_rdata >> {ld_offset, 3'b000};
    ld_data    = ld_shifted;
    case (ld_size)
      SIZE_BYTE: ld_data = {{(LSU_XLEN-8){ld_sgn & ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_HALF: ld_data = {{(LSU_XLEN-16){ld_sgn & ld_shifted[15]}}, ld_shifted[15:0]};
      default:   ld_data = ld_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_ctrl : memory-stage load/store request controller with watchdog  rev 1.0
// ----------------------------------------------------------------------------
module lsu_ctrl
  import ysyx_23060251_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            in_wen_i,
  input  logic            in_ren_i,
  input  logic            in_signed_i,
  input  logic [1:0]      in_size_i,
  input  logic [XLEN-1:0] in_addr_i,
  input  logic [XLEN-1:0] in_wdata_i,
  input  logic [4:0]      in_rd_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [7:0]      mem_mask_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic            mem_err_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_data_o,
  output logic [4:0]      out_rd_o,
  output logic            out_wen_rf_o,
  output logic [1:0]      out_exc_o
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state;
  lsu_op_t          op;
  logic [CNT_W-1:0] wd_cnt;

  logic            a_wen;
  logic            a_ren;
  logic [1:0]      a_size;
  logic [1:0]      a_offset;
  logic [XLEN-1:0] a_wdata;
  logic [7:0]      st_mask;
  logic [XLEN-1:0] st_wdata_sh;
  logic            misaligned;
  logic            illegal;
  logic [XLEN-1:0] ld_data;

  // The store/check side looks at the incoming op while idle and at the held op otherwise.
  always_comb begin
    if (state == ST_IDLE) begin
      a_wen    = in_wen_i;
      a_ren    = in_ren_i;
      a_size   = in_size_i;
      a_offset = in_addr_i[1:0];
      a_wdata  = in_wdata_i;
    end else begin
      a_wen    = op.wen;
      a_ren    = op.ren;
      a_size   = op.size;
      a_offset = op.addr[1:0];
      a_wdata  = op.wdata;
    end
  end

  lsu_align u_align (
    .st_wen      (a_wen),
    .st_ren      (a_ren),
    .st_size     (a_size),
    .st_offset   (a_offset),
    .st_wdata    (a_wdata),
    .st_mask     (st_mask),
    .st_wdata_sh (st_wdata_sh),
    .misaligned  (misaligned),
    .illegal     (illegal),
    .ld_sgn      (op.sgn),
    .ld_size     (op.size),
    .ld_offset   (op.addr[1:0]),
    .ld_rdata    (mem_rdata_i),
    .ld_data     (ld_data)
  );

  assign in_ready_o = (state == ST_IDLE);
  assign mem_addr_o = {op.addr[XLEN-1:2], 2'b00};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      op           <= '0;
      wd_cnt       <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_mask_o   <= '0;
      mem_wdata_o  <= '0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      out_rd_o     <= '0;
      out_wen_rf_o <= 1'b0;
      out_exc_o    <= EXC_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            op <= '{wen: in_wen_i, ren: in_ren_i, sgn: in_signed_i, size: in_size_i,
                    addr: in_addr_i, wdata: in_wdata_i, rd: in_rd_i};
            out_rd_o     <= in_rd_i;
            out_data_o   <= '0;
            out_wen_rf_o <= 1'b0;
            out_exc_o    <= EXC_NONE;
            wd_cnt       <= '0;
            if (illegal) begin
              state       <= ST_DONE;
              out_valid_o <= 1'b1;
              out_exc_o   <= EXC_ILLEGAL;
            end else if (!in_wen_i && !in_ren_i) begin
              state       <= ST_DONE;
              out_valid_o <= 1'b1;
            end else if (misaligned) begin
              state       <= ST_DONE;
              out_valid_o <= 1'b1;
              out_exc_o   <= EXC_MISALIGN;
            end else begin
              state       <= ST_BUSY;
              mem_req_o   <= 1'b1;
              mem_we_o    <= in_wen_i;
              mem_mask_o  <= st_mask;
              mem_wdata_o <= st_wdata_sh;
            end
          end
        end
        ST_BUSY: begin
          // An ack in the final watchdog cycle still completes normally.
          if (mem_ack_i) begin
            state        <= ST_DONE;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            out_valid_o  <= 1'b1;
            out_exc_o    <= mem_err_i ? EXC_FAULT : EXC_NONE;
            out_data_o   <= (op.ren && !mem_err_i) ? ld_data : '0;
            out_wen_rf_o <= op.ren && !mem_err_i && (op.rd != 5'd0);
          end else if (wd_cnt == CNT_LAST) begin
            state       <= ST_DONE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            out_valid_o <= 1'b1;
            out_exc_o   <= EXC_FAULT;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state        <= ST_IDLE;
            out_valid_o  <= 1'b0;
            out_wen_rf_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lsu_ctrl : scoreboard bench for lsu_ctrl (TIMEOUT = 4)            rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_wen = 1'b0, in_ren = 1'b0, in_signed = 1'b0;
  logic [1:0]  in_size = 2'd0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        in_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_mask;
  logic        mem_ack = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen_rf;
  logic [1:0]  out_exc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen_rf;
    logic [1:0]  exc;
  } res_t;

  res_t sb[$];
  res_t exp_r;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_wen_i     (in_wen),
    .in_ren_i     (in_ren),
    .in_signed_i  (in_signed),
    .in_size_i    (in_size),
    .in_addr_i    (in_addr),
    .in_wdata_i   (in_wdata),
    .in_rd_i      (in_rd),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_mask_o   (mem_mask),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_err_i    (mem_err),
    .mem_rdata_i  (mem_rdata),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_rd_o     (out_rd),
    .out_wen_rf_o (out_wen_rf),
    .out_exc_o    (out_exc)
  );

  function automatic res_t model(input logic wen, input logic ren, input logic sgn,
                                 input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] rdata, input logic [4:0] rd,
                                 input bit bus_fail);
    res_t r;
    logic [7:0]  b;
    logic [15:0] h;
    int lo;
    r = '0;
    r.rd = rd;
    lo = int'(addr[1:0]);
    if ((wen && ren) || size == 2'd3) r.exc = 2'd3;
    else if (!wen && !ren) r.exc = 2'd0;
    else if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)) r.exc = 2'd1;
    else if (bus_fail) r.exc = 2'd2;
    else if (ren) begin
      case (size)
        2'd0: begin
          b = rdata[8*lo +: 8];
          r.data = sgn ? {{24{b[7]}}, b} : {24'd0, b};
        end
        2'd1: begin
          h = {rdata[8*lo+8 +: 8], rdata[8*lo +: 8]};
          r.data = sgn ? {{16{h[15]}}, h} : {16'd0, h};
        end
        default: r.data = rdata;
      endcase
      r.wen_rf = (rd != 5'd0);
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [7:0] m;
    int n;
    m = '0;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++)
      if (i >= int'(lo) && i < int'(lo) + n) m[i] = 1'b1;
    return m;
  endfunction

  // Presents one op for a single accepting edge; returns one cycle after acceptance.
  task automatic send(input logic wen, input logic ren, input logic sgn, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    @(negedge clk);
    in_wen = wen; in_ren = ren; in_signed = sgn; in_size = size;
    in_addr = addr; in_wdata = wdata; in_rd = rd; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_wen = 1'b0; in_ren = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({mem_req, mem_we, out_valid, out_wen_rf} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got %b exp 0000", {mem_req, mem_we, out_valid, out_wen_rf}); end
    checks++; if ({mem_addr, mem_mask, mem_wdata} !== '0) begin errors++;
      $display("FAIL reset_mem got %h %h %h exp 0", mem_addr, mem_mask, mem_wdata); end
    checks++; if ({out_data, out_rd, out_exc} !== '0) begin errors++;
      $display("FAIL reset_out got %h %h %h exp 0", out_data, out_rd, out_exc); end
    rst = 1'b0;
  endtask

  task automatic test_load_byte;
    sb.push_back(model(1'b0, 1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h80FF_1234, 5'd7, 1'b0));
    send(1'b0, 1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0, 5'd7);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++;
      $display("FAIL lb_req got req=%b we=%b exp 1 0", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL lb_addr got %h exp 80000000", mem_addr); end
    checks++; if (mem_mask !== 8'h08) begin errors++; $display("FAIL lb_mask got %h exp 08", mem_mask); end
    mem_rdata = 32'h80FF_1234; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lb_latency got valid=%b exp 1", out_valid); end
    exp_r = sb.pop_front();
    checks++; if ({out_data, out_rd, out_wen_rf, out_exc} !== exp_r) begin errors++;
      $display("FAIL lb_result got %h exp %h", {out_data, out_rd, out_wen_rf, out_exc}, exp_r); end
    checks++; if (out_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", out_data); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL lb_return got ready=%b valid=%b exp 1 0", in_ready, out_valid); end
  endtask

  task automatic test_store_half;
    sb.push_back(model(1'b1, 1'b0, 1'b0, 2'd1, 32'h8000_0002, 32'h0, 5'd3, 1'b0));
    send(1'b1, 1'b0, 1'b0, 2'd1, 32'h8000_0002, 32'h0000_BEEF, 5'd3);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_mask !== 8'h0C) begin errors++;
      $display("FAIL sh_req got req=%b we=%b mask=%h exp 1 1 0c", mem_req, mem_we, mem_mask); end
    checks++; if (mem_wdata !== 32'hBEEF_0000) begin errors++; $display("FAIL sh_wdata got %h exp beef0000", mem_wdata); end
    mem_rdata = 32'h1234_5678; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    exp_r = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_data, out_rd, out_wen_rf, out_exc} !== exp_r) begin errors++;
      $display("FAIL sh_result got v=%b %h exp %h", out_valid, {out_data, out_rd, out_wen_rf, out_exc}, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_faults;
    sb.push_back(model(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0001, 32'h0, 5'd4, 1'b0));
    send(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0001, 32'h0, 5'd4);
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1) begin errors++;
      $display("FAIL misalign_timing got req=%b valid=%b exp 0 1", mem_req, out_valid); end
    exp_r = sb.pop_front();
    checks++; if ({out_data, out_rd, out_wen_rf, out_exc} !== exp_r) begin errors++;
      $display("FAIL misalign_result got %h exp %h", {out_data, out_rd, out_wen_rf, out_exc}, exp_r); end
    @(negedge clk);
    sb.push_back(model(1'b0, 1'b1, 1'b0, 2'd3, 32'h8000_0000, 32'h0, 5'd4, 1'b0));
    send(1'b0, 1'b1, 1'b0, 2'd3, 32'h8000_0000, 32'h0, 5'd4);
    exp_r = sb.pop_front();
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_exc !== 2'd3 ||
                  {out_data, out_rd, out_wen_rf, out_exc} !== exp_r) begin errors++;
      $display("FAIL illegal_result got req=%b v=%b %h exp %h", mem_req, out_valid,
               {out_data, out_rd, out_wen_rf, out_exc}, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int  cnt;
    bit  seen;
    cnt = 0; seen = 1'b0;
    sb.push_back(model(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 5'd8, 1'b1));
    send(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 5'd8);
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) cnt++;
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen || cnt != 4) begin errors++; $display("FAIL timeout_req_cycles got %0d seen=%0b exp 4 1", cnt, seen); end
    exp_r = sb.pop_front();
    checks++; if ({out_data, out_rd, out_wen_rf, out_exc} !== exp_r) begin errors++;
      $display("FAIL timeout_result got %h exp %h", {out_data, out_rd, out_wen_rf, out_exc}, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_ack_last;
    int  cnt;
    bit  seen;
    cnt = 0; seen = 1'b0;
    mem_rdata = 32'h1234_5678;
    sb.push_back(model(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0020, 32'h1234_5678, 5'd9, 1'b0));
    send(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0020, 32'h0, 5'd9);
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) begin
        cnt++;
        if (cnt == 4) mem_ack = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || cnt != 4) begin errors++; $display("FAIL ack_last_cycles got %0d seen=%0b exp 4 1", cnt, seen); end
    exp_r = sb.pop_front();
    checks++; if ({out_data, out_rd, out_wen_rf, out_exc} !== exp_r) begin errors++;
      $display("FAIL ack_last_result got %h exp %h", {out_data, out_rd, out_wen_rf, out_exc}, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    sb.push_back(model(1'b0, 1'b1, 1'b1, 2'd1, 32'h8000_0002, 32'h8001_0000, 5'd10, 1'b0));
    send(1'b0, 1'b1, 1'b1, 2'd1, 32'h8000_0002, 32'h0, 5'd10);
    mem_rdata = 32'h8001_0000; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_data, out_rd, out_wen_rf, out_exc} !== sb[0]) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b rdy=%b %h exp 1 0 %h", k, out_valid, in_ready,
                 {out_data, out_rd, out_wen_rf, out_exc}, sb[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_r = sb.pop_front();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL hold_release got v=%b rdy=%b exp 0 1", out_valid, in_ready); end

    sb.push_back(model(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0040, 32'hDEAD_BEEF, 5'd11, 1'b1));
    send(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0040, 32'h0, 5'd11);
    mem_rdata = 32'hDEAD_BEEF; mem_ack = 1'b1; mem_err = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_err = 1'b0;
    exp_r = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_data, out_rd, out_wen_rf, out_exc} !== exp_r) begin errors++;
      $display("FAIL bus_err got v=%b %h exp %h", out_valid, {out_data, out_rd, out_wen_rf, out_exc}, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_reset_busy;
    bit bad;
    bad = 1'b0;
    send(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0050, 32'h0, 5'd12);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_pre got req=%b exp 1", mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL rst_busy_async got req=%b rdy=%b exp 0 1", mem_req, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (4) begin
      if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad) begin errors++; $display("FAIL rst_late_ack got spurious activity exp idle"); end
  endtask

  task automatic test_back_to_back;
    int          kind;
    logic        wen, ren, sgn;
    logic [1:0]  size, lo;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rd;
    for (int n = 0; n < 10; n++) begin
      kind  = int'($urandom_range(0, 4));
      wen   = (kind == 1) || (kind == 3);
      ren   = (kind == 0) || (kind == 3) || (kind == 4);
      size  = 2'($urandom_range(0, 3));
      lo    = 2'($urandom_range(0, 3));
      addr  = {2'b10, 28'($urandom), lo};
      wdata = $urandom;
      rdata = $urandom;
      sgn   = 1'($urandom_range(0, 1));
      rd    = 5'($urandom_range(0, 31));
      sb.push_back(model(wen, ren, sgn, size, addr, rdata, rd, 1'b0));
      send(wen, ren, sgn, size, addr, wdata, rd);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready op%0d got %b exp 0", n, in_ready); end
      if (mem_req === 1'b1) begin
        checks++; if (mem_mask !== exp_mask(size, lo) || mem_we !== wen) begin errors++;
          $display("FAIL b2b_bus op%0d got mask=%h we=%b exp %h %b", n, mem_mask, mem_we, exp_mask(size, lo), wen); end
        mem_rdata = rdata; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
      end
      exp_r = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || {out_data, out_rd, out_wen_rf, out_exc} !== exp_r) begin errors++;
        $display("FAIL b2b_result op%0d got v=%b %h exp %h", n, out_valid, {out_data, out_rd, out_wen_rf, out_exc}, exp_r); end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_faults();
    test_timeout();
    test_ack_last();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
